// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VEND,
    ST_CHANGE
  } state_t;

  typedef logic [3:0] coin_t;
  typedef logic [1:0] prod_id_t;
  typedef logic [6:0] credit_t;

  localparam coin_t COIN_1  = 4'd1;
  localparam coin_t COIN_5  = 4'd5;
  localparam coin_t COIN_10 = 4'd10;

endpackage

// File: rtl/vend_change_pick.sv
// Greedy change selector: largest coin from {10, 5, 1} not exceeding credit.
module vend_change_pick
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 7
) (
  input  logic [CREDIT_W-1:0] credit,
  output coin_t               coin
);

  always_comb begin
    coin = '0;
    if (credit >= CREDIT_W'(COIN_10))
      coin = COIN_10;
    else if (credit >= CREDIT_W'(COIN_5))
      coin = COIN_5;
    else if (credit >= CREDIT_W'(COIN_1))
      coin = COIN_1;
  end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: credit accumulation, product vend and
// coin-by-coin change return. Every output is a register.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 7,
  parameter int MAX_CREDIT  = 50,
  parameter int PRICE_0     = 7,
  parameter int PRICE_1     = 12,
  parameter int PRICE_2     = 15,
  parameter int PRICE_3     = 20,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_strobe,
  input  logic                coin_valid,
  input  logic [3:0]          coin_value,
  input  logic                sel_strobe,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                dispense,
  output logic [1:0]          dispense_id,
  output logic                short_funds,
  output logic                change_valid,
  output logic [3:0]          change_coin,
  input  logic                change_ready,
  output logic                busy
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  if ((PRICE_0 > MAX_CREDIT) || (PRICE_1 > MAX_CREDIT) ||
      (PRICE_2 > MAX_CREDIT) || (PRICE_3 > MAX_CREDIT) ||
      (MAX_CREDIT >= (2 ** CREDIT_W))) begin : g_cfg_error
    $error("vend_txn_ctrl: price above MAX_CREDIT or MAX_CREDIT too wide");
  end

  function automatic logic [CREDIT_W-1:0] price_of(input prod_id_t id);
    case (id)
      2'd0:    return CREDIT_W'(PRICE_0);
      2'd1:    return CREDIT_W'(PRICE_1);
      2'd2:    return CREDIT_W'(PRICE_2);
      default: return CREDIT_W'(PRICE_3);
    endcase
  endfunction

  state_t              state, state_next;
  logic [TMR_W-1:0]    tmr, tmr_next;
  logic [CREDIT_W-1:0] credit_next, price_sel;
  logic                reject_next, disp_next, short_next, coin_ok;
  logic [1:0]          disp_id_next;
  coin_t               pick_coin, change_coin_next;
  logic                change_valid_next, busy_next;

  assign price_sel = price_of(sel_id);
  assign coin_ok   = coin_strobe && coin_valid &&
                     (({1'b0, credit} + SUM_W'(coin_value)) <= SUM_W'(MAX_CREDIT));

  always_comb begin
    state_next   = state;
    credit_next  = credit;
    tmr_next     = tmr;
    reject_next  = 1'b0;
    disp_next    = 1'b0;
    disp_id_next = '0;
    short_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (coin_ok) begin
          credit_next = credit + CREDIT_W'(coin_value);
          tmr_next    = '0;
          state_next  = ST_COLLECT;
        end else begin
          reject_next = coin_strobe;
        end
      end
      ST_COLLECT: begin
        // Priority cancel > select > coin; a coin losing arbitration bounces.
        if (cancel) begin
          reject_next = coin_strobe;
          tmr_next    = '0;
          state_next  = (credit != '0) ? ST_CHANGE : ST_IDLE;
        end else if (sel_strobe) begin
          reject_next = coin_strobe;
          tmr_next    = '0;
          if (credit >= price_sel) begin
            credit_next  = credit - price_sel;
            disp_next    = 1'b1;
            disp_id_next = sel_id;
            state_next   = ST_VEND;
          end else begin
            short_next = 1'b1;
          end
        end else if (coin_ok) begin
          credit_next = credit + CREDIT_W'(coin_value);
          tmr_next    = '0;
        end else begin
          reject_next = coin_strobe;
          if (tmr == TMR_LAST) begin
            tmr_next   = '0;
            state_next = (credit != '0) ? ST_CHANGE : ST_IDLE;
          end else begin
            tmr_next = tmr + 1'b1;
          end
        end
      end
      ST_VEND: begin
        reject_next = coin_strobe;
        state_next  = (credit != '0) ? ST_CHANGE : ST_IDLE;
      end
      default: begin
        reject_next = coin_strobe;
        if (change_valid && change_ready) begin
          credit_next = credit - CREDIT_W'(change_coin);
          if (credit == CREDIT_W'(change_coin))
            state_next = ST_IDLE;
        end
      end
    endcase
  end

  // Coin offer follows the post-update credit, so it holds while the hopper stalls.
  vend_change_pick #(.CREDIT_W(CREDIT_W)) u_pick (
    .credit (credit_next),
    .coin   (pick_coin)
  );

  assign change_valid_next = (state_next == ST_CHANGE);
  assign change_coin_next  = change_valid_next ? pick_coin : '0;
  assign busy_next         = (state_next == ST_VEND) || (state_next == ST_CHANGE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      tmr          <= '0;
      credit       <= '0;
      coin_reject  <= 1'b0;
      dispense     <= 1'b0;
      dispense_id  <= '0;
      short_funds  <= 1'b0;
      change_valid <= 1'b0;
      change_coin  <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      tmr          <= tmr_next;
      credit       <= credit_next;
      coin_reject  <= reject_next;
      dispense     <= disp_next;
      dispense_id  <= disp_id_next;
      short_funds  <= short_next;
      change_valid <= change_valid_next;
      change_coin  <= change_coin_next;
      busy         <= busy_next;
    end
  end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Scoreboard bench for vend_txn_ctrl: directed vectors push expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_vend_txn_ctrl;

  localparam int T_OUT = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_strobe, coin_valid, sel_strobe, cancel, change_ready;
  logic [3:0] coin_value;
  logic [1:0] sel_id;
  logic [6:0] credit;
  logic       coin_reject, dispense, short_funds, change_valid, busy;
  logic [1:0] dispense_id;
  logic [3:0] change_coin;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  int q_rej[$];
  int q_short[$];
  int q_disp[$];
  int q_chg[$];

  vend_txn_ctrl #(
    .CREDIT_W(7), .MAX_CREDIT(50), .PRICE_0(7), .PRICE_1(12),
    .PRICE_2(15), .PRICE_3(20), .TIMEOUT_CYC(T_OUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_strobe  (coin_strobe),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .sel_strobe   (sel_strobe),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .dispense     (dispense),
    .dispense_id  (dispense_id),
    .short_funds  (short_funds),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .change_ready (change_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    int e;
    if (rst_n) begin
      if (coin_reject) begin
        e = (q_rej.size() > 0) ? q_rej.pop_front() : 0;
        chk("coin_reject_event", int'(coin_reject), e);
      end
      if (short_funds) begin
        e = (q_short.size() > 0) ? q_short.pop_front() : 0;
        chk("short_funds_event", int'(short_funds), e);
      end
      if (dispense) begin
        e = (q_disp.size() > 0) ? q_disp.pop_front() : -1;
        chk("dispense_id", int'(dispense_id), e);
      end
      if (change_valid && change_ready) begin
        e = (q_chg.size() > 0) ? q_chg.pop_front() : -1;
        chk("change_coin", int'(change_coin), e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic cv, input logic [3:0] val,
                       input logic s, input logic [1:0] sid, input logic can);
    coin_strobe = c; coin_valid = cv; coin_value = val;
    sel_strobe = s; sel_id = sid; cancel = can;
    tick();
    coin_strobe = 1'b0; coin_valid = 1'b0; coin_value = '0;
    sel_strobe = 1'b0; sel_id = '0; cancel = 1'b0;
  endtask

  task automatic coin(input logic [3:0] val);
    drive(1'b1, 1'b1, val, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy && !change_valid) break;
      tick();
    end
    chk(name, int'(busy | change_valid), 0);
    chk({name, "_credit"}, int'(credit), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; change_ready = 1'b1;
    coin_strobe = 1'b0; coin_valid = 1'b0; coin_value = '0;
    sel_strobe = 1'b0; sel_id = '0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({credit, coin_reject, dispense, dispense_id, short_funds,
                               change_valid, change_coin, busy}), 0);
    rst_n = 1'b1;
    tick();

    // 1: 5+5+1, product 0 at 7 -> change 4 x 1
    coin(4'd5); coin(4'd5); coin(4'd1);
    chk("t1_credit", int'(credit), 11);
    q_disp.push_back(0);
    for (int i = 0; i < 4; i++) q_chg.push_back(1);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 2'd0, 1'b0);
    chk("t1_credit_after_vend", int'(credit), 4);
    wait_idle("t1_idle", 20);

    // 2: short funds, then exact payment for product 2
    coin(4'd10);
    q_short.push_back(1);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 2'd2, 1'b0);
    chk("t2_credit_kept", int'(credit), 10);
    coin(4'd5);
    q_disp.push_back(2);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 2'd2, 1'b0);
    wait_idle("t2_idle", 20);

    // 3: cap at 50, overflow coin and invalid coin bounce
    for (int i = 0; i < 5; i++) coin(4'd10);
    chk("t3_credit_max", int'(credit), 50);
    q_rej.push_back(1);
    coin(4'd1);
    chk("t3_credit_overflow", int'(credit), 50);
    q_rej.push_back(1);
    drive(1'b1, 1'b0, 4'd3, 1'b0, 2'd0, 1'b0);
    chk("t3_credit_invalid", int'(credit), 50);
    for (int i = 0; i < 5; i++) q_chg.push_back(10);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
    wait_idle("t3_idle", 20);

    // 4: cancel with 16, hopper stalls 5 cycles
    coin(4'd10); coin(4'd5); coin(4'd1);
    chk("t4_credit", int'(credit), 16);
    change_ready = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_coin", change_valid ? int'(change_coin) : 0, 10);
      tick();
    end
    chk("t4_hold_credit", int'(credit), 16);
    q_chg.push_back(10); q_chg.push_back(5); q_chg.push_back(1);
    change_ready = 1'b1;
    wait_idle("t4_idle", 20);

    // 5: coin + select + cancel together with credit 12
    coin(4'd10); coin(4'd1); coin(4'd1);
    chk("t5_credit", int'(credit), 12);
    q_rej.push_back(1);
    q_chg.push_back(10); q_chg.push_back(1); q_chg.push_back(1);
    drive(1'b1, 1'b1, 4'd5, 1'b1, 2'd0, 1'b1);
    chk("t5_no_dispense", int'(dispense), 0);
    wait_idle("t5_idle", 20);

    // 6: inactivity refund of 7, then reset in the middle of a refund
    coin(4'd5); coin(4'd1); coin(4'd1);
    q_chg.push_back(5); q_chg.push_back(1); q_chg.push_back(1);
    repeat (T_OUT - 1) tick();
    chk("t6_not_yet_timed_out", int'(change_valid), 0);
    tick();
    chk("t6_timeout_change", int'(change_valid), 1);
    wait_idle("t6_idle", 20);

    coin(4'd10);
    change_ready = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
    chk("t6_in_change", int'(change_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_reset", int'({credit, coin_reject, dispense, dispense_id, short_funds,
                                change_valid, change_coin, busy}), 0);
    tick();
    rst_n = 1'b1;
    change_ready = 1'b1;
    tick(); tick();
    chk("t6_after_reset", int'({credit, change_valid, busy}), 0);

    repeat (3) tick();
    chk("q_reject_drained", q_rej.size(), 0);
    chk("q_short_drained", q_short.size(), 0);
    chk("q_dispense_drained", q_disp.size(), 0);
    chk("q_change_drained", q_chg.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
